// File: rtl/floor_request_manager.sv
// Call-button latch, car position tracker, collective dispatch and door dwell
// timer feeding the elevator control FSM (pending -> solicitud, time_expired -> timeExpired).
module floor_request_manager #(
    parameter int NUM_FLOORS   = 5,
    parameter int DWELL_CYCLES = 50000000,
    parameter int TW           = 26
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] floor_btn,
    input  logic                  floor_sensor,
    input  logic                  motor,
    input  logic                  open_door,
    input  logic                  overweight,
    input  logic                  jammed_door,
    output logic [NUM_FLOORS-1:0] req,
    output logic                  pending,
    output logic [2:0]            current_floor,
    output logic [2:0]            target_floor,
    output logic                  dir_up,
    output logic                  at_target,
    output logic                  time_expired
);

    localparam logic [2:0]    TOP_FLOOR  = 3'(NUM_FLOORS - 1);
    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);

    logic [NUM_FLOORS-1:0] btn_q;
    logic [NUM_FLOORS-1:0] req_q, req_d;
    logic [2:0]            cur_q, cur_d;
    logic [2:0]            tgt_q, tgt_d;
    logic                  dir_q, dir_d;
    logic [TW-1:0]         cnt_q, cnt_d;
    logic                  exp_q, exp_d;

    logic       above, below;
    logic [2:0] lowest_above, highest_below;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q <= '0;
            req_q <= '0;
            cur_q <= 3'd0;
            tgt_q <= 3'd0;
            dir_q <= 1'b1;
            cnt_q <= '0;
            exp_q <= 1'b0;
        end else begin
            btn_q <= floor_btn;
            req_q <= req_d;
            cur_q <= cur_d;
            tgt_q <= tgt_d;
            dir_q <= dir_d;
            cnt_q <= cnt_d;
            exp_q <= exp_d;
        end
    end

    always_comb begin
        req_d         = req_q;
        cur_d         = cur_q;
        tgt_d         = tgt_q;
        dir_d         = dir_q;
        cnt_d         = cnt_q;
        exp_d         = exp_q;
        above         = 1'b0;
        below         = 1'b0;
        lowest_above  = 3'd0;
        highest_below = 3'd0;

        // Clearing the floor being served takes priority over a fresh press there.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (open_door && (cur_q == 3'(i)))
                req_d[i] = 1'b0;
            else
                req_d[i] = req_q[i] | (floor_btn[i] & ~btn_q[i]);
        end

        for (int j = NUM_FLOORS - 1; j >= 0; j--) begin
            if (req_q[j] && (j > int'(cur_q))) begin
                above        = 1'b1;
                lowest_above = 3'(j);
            end
        end
        for (int j = 0; j < NUM_FLOORS; j++) begin
            if (req_q[j] && (j < int'(cur_q))) begin
                below         = 1'b1;
                highest_below = 3'(j);
            end
        end

        if (floor_sensor && motor) begin
            if (dir_q) begin
                if (cur_q < TOP_FLOOR) cur_d = cur_q + 3'd1;
            end else if (cur_q > 3'd0) begin
                cur_d = cur_q - 3'd1;
            end
        end

        // Keep the current sweep direction while requests remain ahead of the car.
        if (!motor) begin
            if (above && (dir_q || !below))
                dir_d = 1'b1;
            else if (below && (!dir_q || !above))
                dir_d = 1'b0;
        end

        if (req_q[cur_q])
            tgt_d = cur_q;
        else if (dir_q && above)
            tgt_d = lowest_above;
        else if (!dir_q && below)
            tgt_d = highest_below;

        if (!open_door || overweight || jammed_door) begin
            cnt_d = '0;
            exp_d = 1'b0;
        end else if (!exp_q) begin
            if (cnt_q == DWELL_LAST)
                exp_d = 1'b1;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    assign req           = req_q;
    assign pending       = |req_q;
    assign current_floor = cur_q;
    assign target_floor  = tgt_q;
    assign dir_up        = dir_q;
    assign at_target     = req_q[cur_q];
    assign time_expired  = exp_q;

endmodule

// File: tb/tb_floor_request_manager.sv
// Bench for floor_request_manager: directed scenarios plus randomized traffic
// compared against a behavioural model of the request, dispatch and dwell rules.
module tb_floor_request_manager;

    localparam int NF    = 5;
    localparam int DWELL = 8;

    logic          clk;
    logic          reset;
    logic [NF-1:0] floor_btn;
    logic          floor_sensor;
    logic          motor;
    logic          open_door;
    logic          overweight;
    logic          jammed_door;
    logic [NF-1:0] req;
    logic          pending;
    logic [2:0]    current_floor;
    logic [2:0]    target_floor;
    logic          dir_up;
    logic          at_target;
    logic          time_expired;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit m_req[NF];
    bit m_prev[NF];
    int m_cur;
    int m_tgt;
    bit m_dir;
    int m_run;

    floor_request_manager #(.NUM_FLOORS(NF), .DWELL_CYCLES(DWELL), .TW(4)) dut (
        .clk(clk), .reset(reset), .floor_btn(floor_btn), .floor_sensor(floor_sensor),
        .motor(motor), .open_door(open_door), .overweight(overweight),
        .jammed_door(jammed_door), .req(req), .pending(pending),
        .current_floor(current_floor), .target_floor(target_floor), .dir_up(dir_up),
        .at_target(at_target), .time_expired(time_expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NF-1:0] m_req_vec();
        logic [NF-1:0] v;
        for (int i = 0; i < NF; i++) v[i] = m_req[i];
        return v;
    endfunction

    function automatic bit m_pending();
        for (int i = 0; i < NF; i++) if (m_req[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NF; i++) begin
            m_req[i]  = 1'b0;
            m_prev[i] = 1'b0;
        end
        m_cur = 0;
        m_tgt = 0;
        m_dir = 1'b1;
        m_run = 0;
    endtask

    task automatic model_edge();
        bit nreq[NF];
        bit above, below;
        int lo, hi;
        int ncur, ntgt;
        bit ndir;
        above = 0; below = 0; lo = -1; hi = -1;
        for (int j = 0; j < NF; j++) begin
            if (m_req[j] && j > m_cur) begin
                if (!above) lo = j;
                above = 1;
            end
            if (m_req[j] && j < m_cur) begin
                below = 1;
                hi = j;
            end
        end
        ndir = m_dir;
        if (!motor) begin
            if (above && (m_dir || !below)) ndir = 1;
            else if (below && (!m_dir || !above)) ndir = 0;
        end
        ntgt = m_tgt;
        if (m_req[m_cur]) ntgt = m_cur;
        else if (m_dir && above) ntgt = lo;
        else if (!m_dir && below) ntgt = hi;
        ncur = m_cur;
        if (floor_sensor && motor) begin
            if (m_dir) ncur = (m_cur + 1 > NF - 1) ? NF - 1 : m_cur + 1;
            else ncur = (m_cur - 1 < 0) ? 0 : m_cur - 1;
        end
        for (int i = 0; i < NF; i++) begin
            if (open_door && m_cur == i) nreq[i] = 0;
            else nreq[i] = m_req[i] | (floor_btn[i] & !m_prev[i]);
        end
        if (open_door && !overweight && !jammed_door)
            m_run = (m_run + 1 > DWELL) ? DWELL : m_run + 1;
        else
            m_run = 0;
        for (int i = 0; i < NF; i++) begin
            m_req[i]  = nreq[i];
            m_prev[i] = floor_btn[i];
        end
        m_cur = ncur;
        m_tgt = ntgt;
        m_dir = ndir;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        floor_btn = '0; floor_sensor = 0; motor = 0; open_door = 0;
        overweight = 0; jammed_door = 0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        floor_btn = '0; floor_sensor = 0; motor = 0; open_door = 0;
        overweight = 0; jammed_door = 0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (req !== 5'b0) begin n_errors++; $display("FAIL reset_req: got %b expected 00000", req); end
        n_checks++; if (pending !== 1'b0) begin n_errors++; $display("FAIL reset_pending: got %b expected 0", pending); end
        n_checks++; if (current_floor !== 3'd0) begin n_errors++; $display("FAIL reset_cur: got %0d expected 0", current_floor); end
        n_checks++; if (target_floor !== 3'd0) begin n_errors++; $display("FAIL reset_tgt: got %0d expected 0", target_floor); end
        n_checks++; if (dir_up !== 1'b1) begin n_errors++; $display("FAIL reset_dir: got %b expected 1", dir_up); end
        n_checks++; if (time_expired !== 1'b0) begin n_errors++; $display("FAIL reset_exp: got %b expected 0", time_expired); end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_latch();
        floor_btn = 5'b01000;
        step();
        n_checks++; if (req !== 5'b01000) begin n_errors++; $display("FAIL latch_req: got %b expected 01000", req); end
        n_checks++; if (pending !== 1'b1) begin n_errors++; $display("FAIL latch_pending: got %b expected 1", pending); end
        step();
        n_checks++; if (dir_up !== 1'b1) begin n_errors++; $display("FAIL latch_dir: got %b expected 1", dir_up); end
        n_checks++; if (target_floor !== 3'd3) begin n_errors++; $display("FAIL latch_tgt: got %0d expected 3", target_floor); end
        step();
        n_checks++; if (req !== 5'b01000) begin n_errors++; $display("FAIL latch_hold: got %b expected 01000", req); end
        floor_btn = '0;
        step();
    endtask

    task automatic test_move();
        motor = 1;
        for (int k = 1; k <= 3; k++) begin
            floor_sensor = 1;
            step();
            floor_sensor = 0;
            n_checks++; if (current_floor !== 3'(k)) begin n_errors++; $display("FAIL move_cur: got %0d expected %0d", current_floor, k); end
            step();
        end
        n_checks++; if (at_target !== 1'b1) begin n_errors++; $display("FAIL move_at_target: got %b expected 1", at_target); end
        motor = 0;
        open_door = 1;
        step();
        n_checks++; if (req !== 5'b0) begin n_errors++; $display("FAIL move_clear: got %b expected 00000", req); end
        n_checks++; if (pending !== 1'b0) begin n_errors++; $display("FAIL move_pending: got %b expected 0", pending); end
        open_door = 0;
        step();
    endtask

    task automatic test_dwell();
        open_door = 1;
        for (int e = 1; e <= DWELL; e++) begin
            step();
            if (e == DWELL - 1) begin
                n_checks++; if (time_expired !== 1'b0) begin n_errors++; $display("FAIL dwell_early: got %b expected 0", time_expired); end
            end
        end
        n_checks++; if (time_expired !== 1'b1) begin n_errors++; $display("FAIL dwell_expire: got %b expected 1", time_expired); end
        open_door = 0;
        step();
        n_checks++; if (time_expired !== 1'b0) begin n_errors++; $display("FAIL dwell_close: got %b expected 0", time_expired); end
        open_door = 1;
        for (int e = 1; e <= 4; e++) step();
        overweight = 1;
        step();
        overweight = 0;
        for (int e = 1; e <= DWELL; e++) begin
            step();
            if (e == DWELL - 1) begin
                n_checks++; if (time_expired !== 1'b0) begin n_errors++; $display("FAIL dwell_fault_early: got %b expected 0", time_expired); end
            end
        end
        n_checks++; if (time_expired !== 1'b1) begin n_errors++; $display("FAIL dwell_fault_expire: got %b expected 1", time_expired); end
        open_door = 0;
        step();
    endtask

    task automatic test_dispatch();
        do_reset();
        floor_btn = 5'b00100;
        step();
        floor_btn = '0;
        motor = 1;
        for (int k = 0; k < 2; k++) begin
            floor_sensor = 1; step();
            floor_sensor = 0; step();
        end
        motor = 0;
        open_door = 1;
        step();
        floor_btn = 5'b00100;
        step();
        n_checks++; if (req[2] !== 1'b0) begin n_errors++; $display("FAIL door_press: got %b expected 0", req[2]); end
        floor_btn = '0;
        floor_sensor = 1;
        step();
        floor_sensor = 0;
        n_checks++; if (current_floor !== 3'd2) begin n_errors++; $display("FAIL sensor_idle: got %0d expected 2", current_floor); end
        open_door = 0;
        step();
        floor_btn = 5'b10001;
        step();
        floor_btn = '0;
        step();
        n_checks++; if (dir_up !== 1'b1) begin n_errors++; $display("FAIL disp_dir_up: got %b expected 1", dir_up); end
        n_checks++; if (target_floor !== 3'd4) begin n_errors++; $display("FAIL disp_tgt4: got %0d expected 4", target_floor); end
        motor = 1;
        for (int k = 0; k < 2; k++) begin
            floor_sensor = 1; step();
            floor_sensor = 0; step();
        end
        n_checks++; if (current_floor !== 3'd4) begin n_errors++; $display("FAIL disp_arrive: got %0d expected 4", current_floor); end
        motor = 0;
        open_door = 1;
        step();
        open_door = 0;
        for (int k = 0; k < 3; k++) step();
        n_checks++; if (req !== 5'b00001) begin n_errors++; $display("FAIL disp_req: got %b expected 00001", req); end
        n_checks++; if (dir_up !== 1'b0) begin n_errors++; $display("FAIL disp_dir_down: got %b expected 0", dir_up); end
        n_checks++; if (target_floor !== 3'd0) begin n_errors++; $display("FAIL disp_tgt0: got %0d expected 0", target_floor); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) floor_btn = 5'($urandom);
            if ($urandom_range(0, 5) == 0) motor = ~motor;
            floor_sensor = motor && ($urandom_range(0, 2) == 0);
            if (motor) open_door = 0;
            else if ($urandom_range(0, 5) == 0) open_door = ~open_door;
            overweight  = ($urandom_range(0, 15) == 0);
            jammed_door = ($urandom_range(0, 15) == 0);
            step();
            n_checks++; if (req !== m_req_vec()) begin n_errors++; $display("FAIL rnd_req c=%0d: got %b expected %b", c, req, m_req_vec()); end
            n_checks++; if (pending !== m_pending()) begin n_errors++; $display("FAIL rnd_pending c=%0d: got %b expected %b", c, pending, m_pending()); end
            n_checks++; if (current_floor !== 3'(m_cur)) begin n_errors++; $display("FAIL rnd_cur c=%0d: got %0d expected %0d", c, current_floor, m_cur); end
            n_checks++; if (target_floor !== 3'(m_tgt)) begin n_errors++; $display("FAIL rnd_tgt c=%0d: got %0d expected %0d", c, target_floor, m_tgt); end
            n_checks++; if (dir_up !== m_dir) begin n_errors++; $display("FAIL rnd_dir c=%0d: got %b expected %b", c, dir_up, m_dir); end
            n_checks++; if (at_target !== m_req[m_cur]) begin n_errors++; $display("FAIL rnd_at_target c=%0d: got %b expected %b", c, at_target, m_req[m_cur]); end
            n_checks++; if (time_expired !== (m_run >= DWELL)) begin n_errors++; $display("FAIL rnd_exp c=%0d: got %b expected %b", c, time_expired, (m_run >= DWELL)); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        floor_btn = 5'b01000;
        step();
        floor_btn = '0;
        motor = 1;
        for (int k = 0; k < 3; k++) begin
            floor_sensor = 1; step();
            floor_sensor = 0; step();
        end
        motor = 0;
        open_door = 1;
        step();
        floor_btn = 5'b10010;
        step();
        floor_btn = '0;
        step();
        motor = 1;
        step();
        n_checks++; if (current_floor !== 3'd3) begin n_errors++; $display("FAIL areset_pre_cur: got %0d expected 3", current_floor); end
        n_checks++; if (req !== 5'b10010) begin n_errors++; $display("FAIL areset_pre_req: got %b expected 10010", req); end
        #1;
        reset = 1'b0;
        #1;
        n_checks++; if (req !== 5'b0) begin n_errors++; $display("FAIL areset_req: got %b expected 00000", req); end
        n_checks++; if (pending !== 1'b0) begin n_errors++; $display("FAIL areset_pending: got %b expected 0", pending); end
        n_checks++; if (current_floor !== 3'd0) begin n_errors++; $display("FAIL areset_cur: got %0d expected 0", current_floor); end
        n_checks++; if (target_floor !== 3'd0) begin n_errors++; $display("FAIL areset_tgt: got %0d expected 0", target_floor); end
        n_checks++; if (dir_up !== 1'b1) begin n_errors++; $display("FAIL areset_dir: got %b expected 1", dir_up); end
        n_checks++; if (time_expired !== 1'b0) begin n_errors++; $display("FAIL areset_exp: got %b expected 0", time_expired); end
        floor_btn = '0; floor_sensor = 0; motor = 0; open_door = 0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        step();
    endtask

    initial begin
        reset = 1'b0;
        floor_btn = '0; floor_sensor = 0; motor = 0; open_door = 0;
        overweight = 0; jammed_door = 0;
        model_reset();
        test_reset();
        test_latch();
        test_move();
        test_dwell();
        test_dispatch();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
